ifetch_prefetch: RTL and testbench
==================================

# ifetch_prefetch

Instruction prefetch stage sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC, issues word fetches to instruction memory over a req/ack handshake, and buffers fetched instructions with their PC+4 in a small FIFO. Decode pulls entries with a valid/ready handshake. A branch/jump redirect flushes the buffer and restarts fetch at the target.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset; word-aligned
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- redirect  in  1  branch/jump taken; flush the buffer and refetch (driven when PCSrc≠0)
- redirect_pc  in  32  new fetch target; bits [1:0] forced to 0 internally
- id_ready  in  1  decode accepts the head entry this cycle (IFIDWrite)
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  fetch address, registered, word-aligned
- imem_ack  in  1  memory returns imem_rdata this cycle; sampled only while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- out_valid  out  1  FIFO non-empty
- out_inst  out  32  head instruction
- out_pc4  out  32  head fetch address + 4
- occupancy  out  log2(DEPTH)+1  current FIFO entry count

## Operation
- State: fetch_pc, FIFO (wr/rd pointers of log2(DEPTH)+1 bits, wrap modulo DEPTH), req flag, drop flag.
- At most one request is outstanding. imem_req, once high, stays high with imem_addr stable until imem_ack.
- Issue rule, evaluated each edge: req_next = 1 iff the count after this cycle's push/pop is < DEPTH. The pending request therefore always has a free slot; the FIFO never overflows.
- On ack with drop=0: push {imem_rdata, imem_addr+4} and advance the address by 4.
- Pop occurs when out_valid & id_ready & !redirect.
- Push and pop in the same cycle leave the count unchanged.
- Redirect (takes priority over everything except reset):
  - The FIFO is emptied and fetch_pc is set to {redirect_pc[31:2],2'b00}.
  - If a request is outstanding and not acked this cycle, drop is set. That request completes later and its data is discarded. The next request then uses the redirect target.
  - If ack arrives in the same cycle as the redirect, the data is discarded and drop stays 0.
  - A redirect while drop=1 updates the target only; still exactly one word is dropped.
- Address arithmetic is 32-bit and wraps: 32'hFFFF_FFFC+4 = 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc4=0, occupancy=0, drop=0.
- First imem_req=1 in the first cycle after rst deasserts (registered at the first rising edge).
- An instruction acked at edge k appears at the head with out_valid=1 in cycle k+1 if the FIFO was empty.
- With zero-wait memory (ack every cycle req is high), throughput is 1 instruction/cycle. imem_addr advances by 4 every cycle.
- Full FIFO: req drops the cycle after the count reaches DEPTH, and reasserts the cycle after the first pop.
- Redirect at edge k: out_valid=0 and occupancy=0 in cycle k+1.
  - Idle memory: imem_req=1 with the target address in cycle k+1.
  - Pending request: the target is issued in the cycle after the dropped ack.
- Reset mid-transaction: all state clears immediately; any late ack is ignored because req=0.

## Test plan
- Reset release, ack tied to req, id_ready=1 -> imem_addr 0,4,8,… on consecutive cycles; out_inst matches memory; out_pc4 = addr+4.
- id_ready=0, DEPTH=4 -> occupancy reaches 4 and imem_req=0. One pop -> req reasserts next cycle; occupancy never exceeds 4.
- Memory with 3-cycle latency, redirect to 32'h100 in the second wait cycle -> the old word is discarded, the next req addr=32'h100, and the first out_inst comes from 0x100.
- Redirect to 32'h203 in the same cycle as ack and pop -> no push, no pop; occupancy=0; next imem_addr=32'h200.
- Reset asserted while a request is outstanding and the FIFO holds 2 entries -> all outputs at reset values asynchronously. After release, fetch restarts at RESET_PC.
- fetch_pc=32'hFFFF_FFF8 with zero-wait memory -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc4 of the second entry = 0.

Source files
------------

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch stage: owns the fetch PC, issues one word fetch at a time
// over req/ack, and queues {inst, pc+4} for decode. A redirect flushes and refetches.
module ifetch_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   input  logic                   id_ready,
   output logic                   imem_req,
   output logic [31:0]            imem_addr,
   input  logic                   imem_ack,
   input  logic [31:0]            imem_rdata,
   output logic                   out_valid,
   output logic [31:0]            out_inst,
   output logic [31:0]            out_pc4,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [31:0] instMem [DEPTH];
   logic [31:0] pc4Mem  [DEPTH];

   logic [AW:0] wrPtr_q, wrPtr_d;
   logic [AW:0] rdPtr_q, rdPtr_d;
   logic [AW:0] count, count_d;
   logic        req_q, req_d;
   logic        drop_q, drop_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] pc_q, pc_d;
   logic        ackSeen, push, pop;

   // pc_q is the address of the next request to issue; addr_q is held while a request is in flight.
   always_comb begin
      ackSeen = req_q & imem_ack;
      push    = ackSeen & ~drop_q & ~redirect;
      pop     = out_valid & id_ready & ~redirect;
      count   = wrPtr_q - rdPtr_q;
      count_d = redirect ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
      wrPtr_d = wrPtr_q + (AW+1)'(push);
      rdPtr_d = redirect ? wrPtr_q : rdPtr_q + (AW+1)'(pop);

      pc_d = pc_q;
      if (redirect) begin
         pc_d = {redirect_pc[31:2], 2'b00};
      end else if (push) begin
         pc_d = addr_q + 32'd4;
      end

      req_d  = (req_q & ~imem_ack) | (count_d != FULL);
      addr_d = (req_q & ~imem_ack) ? addr_q : pc_d;

      drop_d = drop_q;
      if (ackSeen) begin
         drop_d = 1'b0;
      end else if (redirect & req_q) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         req_q   <= 1'b0;
         drop_q  <= 1'b0;
         addr_q  <= RESET_PC;
         pc_q    <= RESET_PC;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         req_q   <= req_d;
         drop_q  <= drop_d;
         addr_q  <= addr_d;
         pc_q    <= pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instMem[wrPtr_q[AW-1:0]] <= imem_rdata;
         pc4Mem[wrPtr_q[AW-1:0]]  <= addr_q + 32'd4;
      end
   end

   // Head data is gated so an empty buffer always presents zeros.
   assign out_valid = (count != '0);
   assign out_inst  = out_valid ? instMem[rdPtr_q[AW-1:0]] : '0;
   assign out_pc4   = out_valid ? pc4Mem[rdPtr_q[AW-1:0]] : '0;
   assign occupancy = count;
   assign imem_req  = req_q;
   assign imem_addr = addr_q;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: the bench plays instruction memory and compares the
// DUT each cycle against a queue-based model of the fetch buffer and fetch PC.
module tb_ifetch_prefetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc4;
   logic [2:0]  occupancy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } entry_t;

   entry_t      modelQ[$];
   logic [31:0] mFetchPc;
   logic [31:0] mAddr;
   bit          mReq;
   bit          mDrop;

   ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .id_ready(id_ready), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .out_valid(out_valid),
      .out_inst(out_inst), .out_pc4(out_pc4), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a ^ 32'hA5A5_5A5A) + {a[15:0], a[31:16]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      modelQ.delete();
      mFetchPc = 32'h0;
      mAddr    = 32'h0;
      mReq     = 1'b0;
      mDrop    = 1'b0;
   endtask

   // One clock edge of the fetch rules: flush or pop/push, then decide the next request.
   task automatic modelStep(input bit rd, input logic [31:0] rpc, input bit idr, input bit ack);
      bit     acked;
      entry_t e;
      acked = mReq && ack;
      if (rd) begin
         modelQ.delete();
         mFetchPc = {rpc[31:2], 2'b00};
      end else begin
         if (idr && modelQ.size() > 0) void'(modelQ.pop_front());
         if (acked && !mDrop) begin
            e.inst = memWord(mAddr);
            e.pc4  = mAddr + 32'd4;
            modelQ.push_back(e);
            mFetchPc = mAddr + 32'd4;
         end
      end
      if (acked) mDrop = 1'b0;
      else if (rd && mReq) mDrop = 1'b1;
      if (!(mReq && !acked)) begin
         mReq  = modelQ.size() < DEPTH;
         mAddr = mFetchPc;
      end
   endtask

   task automatic compareModel();
      checkOutput("req", 32'(imem_req), 32'(mReq));
      if (mReq) checkOutput("addr", imem_addr, mAddr);
      checkOutput("valid", 32'(out_valid), 32'(modelQ.size() > 0));
      checkOutput("occ", 32'(occupancy), 32'(modelQ.size()));
      if (modelQ.size() > 0) begin
         checkOutput("inst", out_inst, modelQ[0].inst);
         checkOutput("pc4", out_pc4, modelQ[0].pc4);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "Req"}, 32'(imem_req), 32'h0);
      checkOutput({tag, "Addr"}, imem_addr, 32'h0);
      checkOutput({tag, "Valid"}, 32'(out_valid), 32'h0);
      checkOutput({tag, "Inst"}, out_inst, 32'h0);
      checkOutput({tag, "Pc4"}, out_pc4, 32'h0);
      checkOutput({tag, "Occ"}, 32'(occupancy), 32'h0);
   endtask

   // Called just after a falling edge; drives one cycle of inputs and checks the result.
   task automatic applyStimulus(input bit rd, input logic [31:0] rpc, input bit idr, input bit ack);
      redirect    = rd;
      redirect_pc = rpc;
      id_ready    = idr;
      imem_ack    = ack;
      imem_rdata  = memWord(imem_addr);
      @(posedge clk);
      modelStep(rd, rpc, idr, ack);
      @(negedge clk);
      compareModel();
   endtask

   initial begin
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkReset("rst");
      rst = 1'b1;

      // Zero-wait memory, decode always ready: one word per cycle from address 0.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("firstAddr", imem_addr, 32'h0);
      checkOutput("firstReq", 32'(imem_req), 32'h1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

      // Decode stalled: buffer fills to DEPTH and the request drops.
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("fullOcc", 32'(occupancy), 32'd4);
      checkOutput("fullReq", 32'(imem_req), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("popReq", 32'(imem_req), 32'h1);
      checkOutput("popOcc", 32'(occupancy), 32'd3);

      // Slow memory with a redirect while the request waits: that word is dropped.
      applyStimulus(1'b1, 32'h1000, 1'b0, 1'b1);
      checkOutput("flushOcc", 32'(occupancy), 32'd0);
      checkOutput("flushAddr", imem_addr, 32'h1000);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("dropOcc", 32'(occupancy), 32'd0);
      checkOutput("dropAddr", imem_addr, 32'h100);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("tgtInst", out_inst, memWord(32'h100));
      checkOutput("tgtPc4", out_pc4, 32'h104);

      // Redirect, ack and pop on the same edge: nothing pushed or popped.
      applyStimulus(1'b1, 32'h203, 1'b1, 1'b1);
      checkOutput("sameOcc", 32'(occupancy), 32'd0);
      checkOutput("sameAddr", imem_addr, 32'h200);

      // Address wrap past the top of memory.
      applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
      checkOutput("wrapA0", imem_addr, 32'hFFFF_FFF8);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("wrapA1", imem_addr, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("wrapA2", imem_addr, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("wrapPc4", out_pc4, 32'h0);
      checkOutput("preRstOcc", 32'(occupancy), 32'd2);

      // Asynchronous reset with a request in flight and two entries buffered.
      #2 rst = 1'b0;
      imem_ack = 1'b1;
      #1 checkReset("midRst");
      modelReset();
      @(posedge clk);
      @(negedge clk);
      checkOutput("inRstReq", 32'(imem_req), 32'h0);
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("restartAddr", imem_addr, 32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 11) == 0), $urandom, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 2) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
